// File: rtl/fp_product_accumulator_if.sv
// Product stream in / batch result out for fp_product_accumulator.
// Handshake: a product transfers on a rising clk edge where in_valid && in_ready; acc_valid is an unconditional one-cycle pulse.
interface fp_product_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_overflow;
    logic        in_last;
    logic        acc_valid;
    logic [31:0] acc_result;
    logic        acc_overflow;
    logic        busy;

    modport master (
        output in_valid, in_data, in_overflow, in_last,
        input  in_ready, acc_valid, acc_result, acc_overflow, busy
    );

    modport slave (
        input  in_valid, in_data, in_overflow, in_last,
        output in_ready, acc_valid, acc_result, acc_overflow, busy
    );
endinterface

// File: rtl/fp_product_accumulator.sv
// Sequential IEEE-754 single-precision product accumulator (truncating, denormals flushed, exp 0xFF = infinity).
// Optional feature macro: FP_ACC_COUNT_EN adds the acc_count element counter output.
module fp_product_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    fp_product_accumulator_if.slave bus,
`ifdef FP_ACC_COUNT_EN
    output logic [CNT_W-1:0]        acc_count,
`endif
    output logic [2:0]              dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] op_q, op_d;
    logic        last_q, last_d;
    logic        sticky_q, sticky_d;
    logic        inf_sign_q, inf_sign_d;
    logic        sign_q, sign_d;
    logic        sb_q, sb_d;
    logic [7:0]  exp_q, exp_d;
    logic [24:0] mant_q, mant_d;
    logic [23:0] mb_q, mb_d;
    logic        zero_q, zero_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
`ifdef FP_ACC_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
`endif

    logic        fire;
    logic [31:0] wr_word;
    logic [23:0] a_man, b_man;
    logic [7:0]  diff;
    logic [24:0] sum;

    assign fire    = bus.in_valid && bus.in_ready;
    // Once saturated the total is pinned to the first infinity's sign.
    assign wr_word = sticky_q ? {inf_sign_q, 8'hFF, 23'd0}
                   : (zero_q ? 32'd0 : {sign_q, exp_q, mant_q[22:0]});

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        last_d     = last_q;
        sticky_d   = sticky_q;
        inf_sign_d = inf_sign_q;
        sign_d     = sign_q;
        sb_d       = sb_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        mb_d       = mb_q;
        zero_d     = zero_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
`ifdef FP_ACC_COUNT_EN
        cnt_d      = cnt_q;
        cnt_out_d  = cnt_out_q;
`endif
        a_man = {1'b1, acc_q[22:0]};
        b_man = {1'b1, op_q[22:0]};
        diff  = 8'd0;
        sum   = 25'd0;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    op_d   = bus.in_data;
                    last_d = bus.in_last;
`ifdef FP_ACC_COUNT_EN
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`endif
                    if (bus.in_data[30:23] == 8'hFF || bus.in_overflow) begin
                        if (!sticky_q) inf_sign_d = bus.in_data[31];
                        sticky_d = 1'b1;
                        state_d  = WRITE;
                    end else if (bus.in_data[30:23] == 8'h00 || sticky_q) begin
                        sign_d  = acc_q[31];
                        exp_d   = acc_q[30:23];
                        mant_d  = {2'b01, acc_q[22:0]};
                        zero_d  = (acc_q[30:23] == 8'h00);
                        state_d = WRITE;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                zero_d = 1'b0;
                sign_d = acc_q[31];
                sb_d   = op_q[31];
                if (acc_q[30:23] == 8'h00) begin
                    sign_d  = op_q[31];
                    exp_d   = op_q[30:23];
                    mant_d  = {2'b01, op_q[22:0]};
                    state_d = WRITE;
                end else if (acc_q[30:23] >= op_q[30:23]) begin
                    diff    = acc_q[30:23] - op_q[30:23];
                    exp_d   = acc_q[30:23];
                    mant_d  = {1'b0, a_man};
                    mb_d    = (diff >= 8'd25) ? 24'd0 : (b_man >> diff[4:0]);
                    state_d = ADD;
                end else begin
                    diff    = op_q[30:23] - acc_q[30:23];
                    exp_d   = op_q[30:23];
                    mant_d  = {1'b0, ((diff >= 8'd25) ? 24'd0 : (a_man >> diff[4:0]))};
                    mb_d    = b_man;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sign_q == sb_q) begin
                    sum = mant_q + {1'b0, mb_q};
                end else if (mant_q[23:0] > mb_q) begin
                    sum = mant_q - {1'b0, mb_q};
                end else if (mant_q[23:0] < mb_q) begin
                    sum    = {1'b0, mb_q} - mant_q;
                    sign_d = sb_q;
                end
                mant_d = sum;
                if (sum == 25'd0) begin
                    zero_d  = 1'b1;
                    state_d = WRITE;
                end else begin
                    state_d = (sum[24] || !sum[23]) ? NORM : WRITE;
                end
            end
            NORM: begin
                if (mant_q[24]) begin
                    if (exp_q == 8'd254) begin
                        sticky_d   = 1'b1;
                        inf_sign_d = sign_q;
                    end
                    mant_d  = mant_q >> 1;
                    exp_d   = exp_q + 8'd1;
                    state_d = WRITE;
                end else if (exp_q == 8'd1) begin
                    zero_d  = 1'b1;
                    state_d = WRITE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 8'd1;
                    if (mant_q[22]) state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d   = wr_word;
                state_d = IDLE;
                if (last_q) begin
                    res_d    = wr_word;
                    ovf_d    = sticky_q;
                    acc_d    = 32'd0;
                    sticky_d = 1'b0;
`ifdef FP_ACC_COUNT_EN
                    cnt_out_d = cnt_q;
                    cnt_d     = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d  = IDLE;
            acc_d    = 32'd0;
            sticky_d = 1'b0;
`ifdef FP_ACC_COUNT_EN
            cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 32'd0;
            op_q       <= 32'd0;
            last_q     <= 1'b0;
            sticky_q   <= 1'b0;
            inf_sign_q <= 1'b0;
            sign_q     <= 1'b0;
            sb_q       <= 1'b0;
            exp_q      <= 8'd0;
            mant_q     <= 25'd0;
            mb_q       <= 24'd0;
            zero_q     <= 1'b0;
            res_q      <= 32'd0;
            ovf_q      <= 1'b0;
`ifdef FP_ACC_COUNT_EN
            cnt_q      <= '0;
            cnt_out_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            last_q     <= last_d;
            sticky_q   <= sticky_d;
            inf_sign_q <= inf_sign_d;
            sign_q     <= sign_d;
            sb_q       <= sb_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            mb_q       <= mb_d;
            zero_q     <= zero_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
`ifdef FP_ACC_COUNT_EN
            cnt_q      <= cnt_d;
            cnt_out_q  <= cnt_out_d;
`endif
        end
    end

    // The result pulse is presented in the WRITE cycle itself; the registers hold it afterwards.
    assign bus.in_ready     = (state_q == IDLE) && !clear;
    assign bus.acc_valid    = (state_q == WRITE) && last_q && !clear;
    assign bus.acc_result   = bus.acc_valid ? wr_word : res_q;
    assign bus.acc_overflow = bus.acc_valid ? sticky_q : ovf_q;
    assign bus.busy         = (state_q != IDLE);
    assign dbg_state        = state_q;
`ifdef FP_ACC_COUNT_EN
    assign acc_count        = bus.acc_valid ? cnt_q : cnt_out_q;
`endif
endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed bench for fp_product_accumulator: hand-computed float sums, latency, sticky overflow, clear and reset.
module tb_fp_product_accumulator;
  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [2:0] dbg_state;
`ifdef FP_ACC_COUNT_EN
  logic [15:0] acc_count;
`endif
  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] r;
  logic        o;
  int          p;
  int          b;
  logic [15:0] c;

  fp_product_accumulator_if bus();

  fp_product_accumulator #(.CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bus(bus),
`ifdef FP_ACC_COUNT_EN
    .acc_count(acc_count),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Driver: waits (bounded) for in_ready, presents one product for one cycle.
  task automatic send(input logic [31:0] data, input logic ovf, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data = data;
    bus.in_overflow = ovf;
    bus.in_last = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_overflow = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // Monitor: samples a fixed window, counting busy cycles and result pulses.
  task automatic collect(input int cycles, output logic [31:0] res, output logic ovf,
                         output int pulses, output int busy_cyc, output logic [15:0] cnt);
    res = 32'd0;
    ovf = 1'b0;
    pulses = 0;
    busy_cyc = 0;
    cnt = 16'd0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.busy) busy_cyc++;
      if (bus.acc_valid) begin
        pulses++;
        res = bus.acc_result;
        ovf = bus.acc_overflow;
`ifdef FP_ACC_COUNT_EN
        cnt = acc_count;
`endif
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    bus.in_overflow = 1'b0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid: got %0b want 0", bus.acc_valid); end
    n_checks++; if (bus.acc_result !== 32'h0) begin n_fail++; $display("FAIL reset_acc_result: got %h want 00000000", bus.acc_result); end
    n_checks++; if (bus.acc_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_acc_overflow: got %0b want 0", bus.acc_overflow); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_sum();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL sum_result: got %h want 40400000", r); end
    n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL sum_overflow: got %0b want 0", o); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL sum_pulse_count: got %0d want 1", p); end
    n_checks++; if (b !== 3) begin n_fail++; $display("FAIL sum_busy_cycles: got %0d want 3", b); end
`ifdef FP_ACC_COUNT_EN
    n_checks++; if (c !== 16'd2) begin n_fail++; $display("FAIL sum_count: got %0d want 2", c); end
`endif
    n_checks++; if (bus.acc_result !== 32'h40400000) begin n_fail++; $display("FAIL sum_hold: got %h want 40400000", bus.acc_result); end
  endtask

  task automatic test_cancel();
    send(32'h3FC00000, 1'b0, 1'b0);
    send(32'hBFC00000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL cancel_result: got %h want 00000000", r); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL cancel_pulse_count: got %0d want 1", p); end
    n_checks++; if (b !== 3) begin n_fail++; $display("FAIL cancel_busy_cycles: got %0d want 3", b); end
  endtask

  task automatic test_norm();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'hBF400000, 1'b0, 1'b1);
    collect(40, r, o, p, b, c);
    n_checks++; if (r !== 32'h3E800000) begin n_fail++; $display("FAIL norm_result: got %h want 3E800000", r); end
    n_checks++; if (b !== 5) begin n_fail++; $display("FAIL norm_busy_cycles: got %0d want 5", b); end
  endtask

  task automatic test_carry();
    send(32'h3FC00000, 1'b0, 1'b0);
    send(32'h3FC00000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL carry_result: got %h want 40400000", r); end
    n_checks++; if (b !== 4) begin n_fail++; $display("FAIL carry_busy_cycles: got %0d want 4", b); end
  endtask

  task automatic test_overflow();
    send(32'h7F800000, 1'b1, 1'b0);
    send(32'h3F800000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_result: got %h want 7F800000", r); end
    n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", o); end
    n_checks++; if (b !== 1) begin n_fail++; $display("FAIL ovf_ignored_busy: got %0d want 1", b); end
    n_checks++; if (bus.acc_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %0b want 1", bus.acc_overflow); end
    send(32'h3F800000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL ovf_next_result: got %h want 3F800000", r); end
    n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag: got %0b want 0", o); end
  endtask

  task automatic test_align_limit();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h33800000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL align24_result: got %h want 3F800000", r); end
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h33000000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL align25_result: got %h want 3F800000", r); end
  endtask

  task automatic test_clear();
    send(32'h40000000, 1'b0, 1'b0);
    clear = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %0b want 0", bus.in_ready); end
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %0b want 0", bus.busy); end
    send(32'h3F800000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL clear_result: got %h want 3F800000", r); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL clear_pulse_count: got %0d want 1", p); end
`ifdef FP_ACC_COUNT_EN
    n_checks++; if (c !== 16'd1) begin n_fail++; $display("FAIL clear_count: got %0d want 1", c); end
`endif
  endtask

  task automatic test_reset_mid();
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.acc_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_acc_result: got %h want 00000000", bus.acc_result); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", bus.busy); end
    send(32'h40000000, 1'b0, 1'b1);
    collect(30, r, o, p, b, c);
    n_checks++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL rstmid_result: got %h want 40000000", r); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL rstmid_pulse_count: got %0d want 1", p); end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_cancel();
    test_norm();
    test_carry();
    test_overflow();
    test_align_limit();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_product_accumulator.md
Name: fp_product_accumulator

Overview:
- Sequential single-precision accumulator directly downstream of the floating-point multiplier.
- Consumes the multiplier's result word and overflow flag, one product per handshake, and sums products into a running IEEE-754 total.
- Emits the total at the end of a batch. Together with the multiplier it forms a dot-product / MAC path.
- Same number rules as the multiplier: truncation rounding, denormals flushed to zero, any exponent-0xFF input treated as infinity.

Parameters:
CNT_W, 16, width of the optional element counter; unused unless FP_ACC_COUNT_EN is defined.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous batch abort; priority below rst
in_valid  input  1  product word valid
in_ready  output  1  block can accept a product
in_data  input  32  product from multiplier (sign, exp[7:0], frac[22:0])
in_overflow  input  1  multiplier overflow flag for this product
in_last  input  1  product is the final element of the batch
acc_valid  output  1  one-cycle pulse: acc_result/acc_overflow valid
acc_result  output  32  batch sum
acc_overflow  output  1  sticky: batch saturated to infinity
busy  output  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: accumulator 0x00000000, state IDLE, acc_valid 0, acc_result 0x00000000, acc_overflow 0, sticky flag 0, busy 0. in_ready is 1 after reset.
- Handshake: in_ready = (state==IDLE) && !clear. A transfer happens on a cycle with in_valid && in_ready.
- On transfer: latch in_data, in_overflow and in_last. Then:
  - exp==0xFF or in_overflow=1: set sticky, go to WRITE.
  - exp==0: input is zero, go to WRITE.
  - otherwise: go to ALIGN.
- ALIGN (1 cycle):
  - Form 24-bit mantissas with the hidden bit. An accumulator value of 0 is treated as an exact zero; skip straight to WRITE with the input as the result.
  - Right-shift the smaller-exponent mantissa by the exponent difference. A difference of 25 or more gives 0. Shifted-out bits are discarded.
  - Result exponent = larger exponent.
- ADD (1 cycle), 25-bit datapath:
  - Same signs: add magnitudes.
  - Different signs: subtract the smaller magnitude from the larger; result takes the sign of the larger.
  - Equal magnitudes: result is +0, go to WRITE.
- NORM:
  - If bit24 is set: shift right by 1, exp+1, in one cycle. If exp reaches 255, set sticky and the result becomes infinity.
  - Else, while bit23==0: shift left 1 and exp-1, one bit per cycle. If exp would drop to 0, flush the result to signed zero (→ +0).
  - Exit when bit23==1.
- WRITE (1 cycle):
  - accumulator <= result. If sticky is set, accumulator is {sign of first inf/overflow input, 0xFF, 0} and later inputs are accepted but ignored.
  - If last is latched: acc_valid=1 for this cycle; acc_result = new value; acc_overflow = sticky. Next cycle the accumulator and sticky flag clear to 0.
  - Return to IDLE.
- acc_result and acc_overflow hold their values between pulses.
- Latency, transfer to WRITE:
  - zero or special input: 1 cycle.
  - normal input: 3 cycles + 1 per left-normalisation shift (maximum 23).
- clear: in any state, returns to IDLE, clears the accumulator and sticky flag, drops the in-flight operand, no acc_valid. clear on a valid cycle prevents acceptance (in_ready=0).
- rst mid-operation: same as clear, and additionally resets acc_result and acc_overflow.
- Back-to-back: at most one product every 2 cycles (IDLE is required between operations).

Optional Feature:
FP_ACC_COUNT_EN:
- Defined: adds output acc_count [CNT_W-1:0], the number of transfers in the current batch including the last.
  - Saturates at all-ones.
  - Valid with acc_valid; holds between pulses.
  - Reset and clear to 0.
- Undefined: no port, no counter logic.

Test Plan:
- 3F800000, then 40000000 with in_last → acc_result 40400000, acc_overflow 0, acc_valid high exactly 1 cycle.
- 3FC00000, then BFC00000 last → acc_result 00000000, no NORM cycles.
- 3F800000, then BF400000 last → 3E800000. Second op: busy high 5 cycles, including 2 NORM shifts.
- 7F800000 with in_overflow=1, then 3F800000 last → acc_result 7F800000, acc_overflow 1. Next batch 3F800000 last → 3F800000, acc_overflow 0.
- 3F800000, then 33800000 last (exponent difference 24) → 3F800000 (truncated). 3F800000 then 33000000 (difference 25) → 3F800000.
- Send 40000000; assert clear during ALIGN; then 3F800000 last → 3F800000. With FP_ACC_COUNT_EN defined, acc_count=1.
